// File: rtl/mul_tree_sched.sv
// ---------------------------------------------------------------------------
// mul_tree_sched
//
// Burst scheduler between an upstream line stream and the multiplier tree.
// A run is started with cfg_start in IDLE. Each run:
//   1. streams exactly LINES_PER_NODE lines per node into the tree.
//   2. waits GAP_CYCLES idle cycles between nodes so the tree can drain.
//   3. after the last node, collects the tree's max exponent.
//   4. pulses done.
// mode is latched at the accepted start and held for the whole run.
//
// Handshake rule: a beat moves on a rising clk edge where valid and ready
// are both high. valid never depends on ready. While streaming, the
// upstream and tree handshakes are wired straight through with no register
// stage, so one upstream beat is exactly one tree beat.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   cfg_start         start pulse, honoured only in IDLE
//   cfg_mode          tree mode, latched at an accepted start
//   cfg_num_nodes     node bursts per run, latched at an accepted start
//   s_data/s_vld/s_rdy        upstream line stream
//   m_data/m_vld/m_rdy        tree input stream
//   mode              tree mode for the current run
//   max_exp_rdy/max_exp/max_exp_vld  max-exponent handshake with the tree
//   busy              high whenever not IDLE
//   node_idx          0-based index of the node being streamed
//   done              one-cycle pulse at the end of a run
//   result_exp/result_vld     captured max exponent; result_vld clears at
//                             the next accepted start
//   state_dbg         current FSM state, for debug and checkers
//   stall_cycles/starve_cycles  (only with MUL_TREE_SCHED_PERF_EN)
//       saturating counts of STREAM cycles blocked by the tree or
//       starved by upstream
//
// Optional feature macro: MUL_TREE_SCHED_PERF_EN
// ---------------------------------------------------------------------------
module mul_tree_sched #(
    parameter int IN_W           = 256,
    parameter int LINES_PER_NODE = 256,
    parameter int GAP_CYCLES     = 5120,
    parameter int NODE_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [1:0]        cfg_mode,
    input  logic [NODE_W-1:0] cfg_num_nodes,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_vld,
    output logic              s_rdy,
    output logic [IN_W-1:0]   m_data,
    output logic              m_vld,
    input  logic              m_rdy,
    output logic [1:0]        mode,
    output logic              max_exp_rdy,
    input  logic [7:0]        max_exp,
    input  logic              max_exp_vld,
    output logic              busy,
    output logic [NODE_W-1:0] node_idx,
    output logic              done,
    output logic [7:0]        result_exp,
    output logic              result_vld,
`ifdef MUL_TREE_SCHED_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       starve_cycles,
`endif
    output logic [2:0]        state_dbg
);

    localparam int LC_W  = (LINES_PER_NODE > 1) ? $clog2(LINES_PER_NODE) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(LINES_PER_NODE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STREAM  = 3'd1,
        S_GAP     = 3'd2,
        S_COLLECT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [NODE_W-1:0] num_nodes;
    logic [LC_W-1:0]   line_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic in_stream;
    logic xfer;
    logic line_last;
    logic node_last;
    logic exp_hs;
    logic start_acc;
    logic node_adv;

    assign in_stream = (state == S_STREAM);
    assign xfer      = in_stream & s_vld & m_rdy;
    assign line_last = (line_cnt == LC_LAST);
    assign node_last = (node_idx == (num_nodes - NODE_W'(1)));
    assign exp_hs    = (state == S_COLLECT) & max_exp_vld & max_exp_rdy;

    // Zero-latency pass-through while streaming; data is a don't-care
    // outside STREAM, so it simply keeps following upstream.
    assign m_data    = s_data;
    assign m_vld     = in_stream & s_vld;
    assign s_rdy     = in_stream & m_rdy;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        node_adv  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    start_acc = 1'b1;
                    // An empty run skips straight to the done pulse.
                    state_nxt = (cfg_num_nodes != '0) ? S_STREAM : S_FINISH;
                end
            end
            S_STREAM: begin
                if (xfer && line_last) begin
                    if (node_last) begin
                        state_nxt = S_COLLECT;
                    end else if (GAP_CYCLES == 0) begin
                        node_adv  = 1'b1;
                        state_nxt = S_STREAM;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    node_adv  = 1'b1;
                    state_nxt = S_STREAM;
                end
            end
            S_COLLECT: begin
                if (exp_hs) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode        <= 2'b00;
            num_nodes   <= '0;
            node_idx    <= '0;
            line_cnt    <= '0;
            gap_cnt     <= '0;
            max_exp_rdy <= 1'b0;
            done        <= 1'b0;
            result_exp  <= 8'h00;
            result_vld  <= 1'b0;
        end else begin
            if (start_acc) begin
                mode       <= cfg_mode;
                num_nodes  <= cfg_num_nodes;
                node_idx   <= '0;
                line_cnt   <= '0;
                gap_cnt    <= '0;
                result_vld <= 1'b0;
            end
            if (xfer) begin
                line_cnt <= line_last ? '0 : line_cnt + 1'b1;
            end
            if (state == S_GAP) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            end
            if (node_adv) begin
                node_idx <= node_idx + 1'b1;
            end
            // Registered ready: rises the cycle after COLLECT is entered and
            // drops right after the exponent is taken.
            max_exp_rdy <= (state == S_COLLECT) & ~exp_hs;
            if (exp_hs) begin
                result_exp <= max_exp;
                result_vld <= 1'b1;
            end
            done <= (state == S_FINISH);
        end
    end

`ifdef MUL_TREE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else if (start_acc) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else if (in_stream) begin
            if (s_vld && !m_rdy && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (!s_vld && (starve_cycles != '1)) begin
                starve_cycles <= starve_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_tree_sched.sv
// Bench for mul_tree_sched with LINES_PER_NODE=4, GAP_CYCLES=3.
// Inputs change 1ns after the rising edge; everything is sampled on the
// falling edge. A monitor pops the expected {node_idx, line} queue on every
// tree-side handshake.
module tb_mul_tree_sched;
    localparam int IN_W   = 32;
    localparam int LPN    = 4;
    localparam int GAPC   = 3;
    localparam int NODE_W = 8;
    localparam int EW     = NODE_W + IN_W;

    logic              clk;
    logic              rst;
    logic              cfg_start;
    logic [1:0]        cfg_mode;
    logic [NODE_W-1:0] cfg_num_nodes;
    logic [IN_W-1:0]   s_data;
    logic              s_vld;
    logic              s_rdy;
    logic [IN_W-1:0]   m_data;
    logic              m_vld;
    logic              m_rdy;
    logic [1:0]        mode;
    logic              max_exp_rdy;
    logic [7:0]        max_exp;
    logic              max_exp_vld;
    logic              busy;
    logic [NODE_W-1:0] node_idx;
    logic              done;
    logic [7:0]        result_exp;
    logic              result_vld;
    logic [2:0]        state_dbg;
`ifdef MUL_TREE_SCHED_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       starve_cycles;
`endif

    mul_tree_sched #(
        .IN_W(IN_W), .LINES_PER_NODE(LPN), .GAP_CYCLES(GAPC), .NODE_W(NODE_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_num_nodes(cfg_num_nodes),
        .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
        .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy),
        .mode(mode),
        .max_exp_rdy(max_exp_rdy), .max_exp(max_exp), .max_exp_vld(max_exp_vld),
        .busy(busy), .node_idx(node_idx), .done(done),
        .result_exp(result_exp), .result_vld(result_vld),
`ifdef MUL_TREE_SCHED_PERF_EN
        .stall_cycles(stall_cycles), .starve_cycles(starve_cycles),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;
    logic [1:0]    exp_mode;
    int done_cnt = 0;
    int mvld_cnt = 0;
    int mxr_cnt  = 0;
    int xfer_cnt = 0;

    logic [IN_W-1:0] src_vec [0:31];
    int src_ptr = 0;

    logic smp_s_rdy, smp_mxr, smp_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (done)        done_cnt++;
            if (m_vld)       mvld_cnt++;
            if (max_exp_rdy) mxr_cnt++;
            if (m_vld && m_rdy) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL xfer_unexpected: got node %0d data %0h, expected no transfer",
                             node_idx, m_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("xfer_node_data", {24'd0, node_idx, m_data}, {24'd0, exp_e});
                end
                chk("passthru", {32'd0, m_data}, {32'd0, s_data});
                chk("mode_run", {62'd0, mode}, {62'd0, exp_mode});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One clock cycle: sample at the falling edge, then advance the
    // upstream source if its line was accepted, 1ns after the rising edge.
    task automatic tick();
        bit hs;
        @(negedge clk);
        smp_s_rdy = s_rdy;
        smp_mxr   = max_exp_rdy;
        smp_done  = done;
        hs        = s_vld && s_rdy;
        @(posedge clk);
        #1;
        if (hs) begin
            src_ptr = (src_ptr + 1) % 32;
            s_data  = src_vec[src_ptr];
        end
    endtask

    task automatic push_lines(input int n, input int lines_per_node);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back({NODE_W'(j / lines_per_node), src_vec[(src_ptr + j) % 32]});
        end
    endtask

    task automatic start_run(input logic [1:0] md, input logic [NODE_W-1:0] nn);
        cfg_start     = 1'b1;
        cfg_mode      = md;
        cfg_num_nodes = nn;
    endtask

    // Runs until done, answering the exponent handshake with ans.
    task automatic run_to_done(input bit toggle, input logic [7:0] ans, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            cfg_start = 1'b0;
            if (toggle) m_rdy = ~m_rdy;
            if (smp_mxr) begin
                max_exp     = ans;
                max_exp_vld = 1'b1;
            end
            if (smp_done) seen = 1'b1;
        end
        max_exp_vld = 1'b0;
        chk("done_seen", {63'd0, seen}, 64'd1);
    endtask

    // ---------------- main sequence ----------------
    logic [13:0] rdy_tr, mxr_tr;
    logic [3:0]  done_tr;
    int d0, m0, x0, r0;
`ifdef MUL_TREE_SCHED_PERF_EN
    logic [8:0] pv_vld, pv_rdy;
`endif

    initial begin
        for (int i = 0; i < 32; i++) begin
            src_vec[i] = {8'hA5, 8'(i), 8'(8'hFF - i), 8'h3C};
        end
        rst = 1'b0;
        cfg_start = 1'b0; cfg_mode = 2'b00; cfg_num_nodes = '0;
        s_vld = 1'b0; m_rdy = 1'b0; max_exp = 8'h00; max_exp_vld = 1'b0;
        s_data = src_vec[0];
        exp_mode = 2'b00;
        tick(); tick();

        // Reset state
        chk("rst_state", {61'd0, state_dbg}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mode", {62'd0, mode}, 64'd0);
        chk("rst_mxr", {63'd0, max_exp_rdy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {55'd0, result_vld, result_exp}, 64'd0);
        chk("rst_node", {56'd0, node_idx}, 64'd0);
        rst = 1'b1;
        tick();

        // Basic run, with an ignored start (mode 01, 5 nodes) during GAP.
        exp_mode = 2'b10;
        push_lines(8, LPN);
        s_vld = 1'b1; m_rdy = 1'b1;
        start_run(2'b10, 8'd2);
        for (int i = 0; i < 14; i++) begin
            tick();
            rdy_tr[i] = smp_s_rdy;
            mxr_tr[i] = smp_mxr;
            if (i + 1 == 6) begin
                start_run(2'b01, 8'd5);
            end else begin
                cfg_start = 1'b0;
                cfg_mode  = 2'b10;
                cfg_num_nodes = 8'd2;
            end
        end
        chk("basic_s_rdy_trace", {50'd0, rdy_tr}, 64'h0F1E);
        chk("basic_mxr_trace", {50'd0, mxr_tr}, 64'h2000);
        d0 = done_cnt;
        max_exp = 8'h7A; max_exp_vld = 1'b1;
        run_to_done(1'b0, 8'h7A, 10);
        tick(); tick();
        chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
        chk("basic_result", {55'd0, result_vld, result_exp}, {55'd0, 1'b1, 8'h7A});
        chk("basic_mode_hold", {62'd0, mode}, 64'h2);
        chk("busy_start_node", {56'd0, node_idx}, 64'd1);
        chk("basic_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: tree ready toggles every cycle.
        exp_mode = 2'b11;
        x0 = xfer_cnt;
        push_lines(8, LPN);
        m_rdy = 1'b1;
        start_run(2'b11, 8'd2);
        run_to_done(1'b1, 8'h3C, 100);
        chk("bp_xfers", 64'(xfer_cnt - x0), 64'd8);
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_result", {56'd0, result_exp}, 64'h3C);

        // Zero nodes: done two cycles after start, nothing streamed.
        d0 = done_cnt; m0 = mvld_cnt; r0 = mxr_cnt; x0 = xfer_cnt;
        s_vld = 1'b1; m_rdy = 1'b1;
        start_run(2'b10, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            cfg_start = 1'b0;
            done_tr[i] = smp_done;
        end
        chk("zero_done_trace", {60'd0, done_tr}, 64'h4);
        chk("zero_no_mvld", 64'(mvld_cnt - m0), 64'd0);
        chk("zero_no_mxr", 64'(mxr_cnt - r0), 64'd0);
        chk("zero_result_vld", {63'd0, result_vld}, 64'd0);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

        // Reset mid-burst: node 0 plus two lines of node 1, then reset.
        exp_mode = 2'b10;
        push_lines(6, LPN);
        start_run(2'b10, 8'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            cfg_start = 1'b0;
        end
        chk("mid_q_empty", 64'(exp_q.size()), 64'd0);
        chk("mid_node", {56'd0, node_idx}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", {61'd0, state_dbg}, 64'd0);
        chk("arst_outs", {57'd0, busy, m_vld, s_rdy, max_exp_rdy, done, mode},
            64'd0);
        chk("arst_node", {56'd0, node_idx}, 64'd0);
        chk("arst_result", {55'd0, result_vld, result_exp}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        exp_mode = 2'b01;
        x0 = xfer_cnt;
        push_lines(4, LPN);
        start_run(2'b01, 8'd1);
        run_to_done(1'b0, 8'h05, 40);
        chk("post_rst_xfers", 64'(xfer_cnt - x0), 64'd4);
        chk("post_rst_q_empty", 64'(exp_q.size()), 64'd0);
        chk("post_rst_result", {55'd0, result_vld, result_exp}, {55'd0, 1'b1, 8'h05});

`ifdef MUL_TREE_SCHED_PERF_EN
        // Perf counters: 3 tree stalls and 2 upstream starves in one burst.
        pv_vld = 9'b111_011_011;
        pv_rdy = 9'b110_110_110;
        exp_mode = 2'b11;
        push_lines(4, LPN);
        s_vld = 1'b1; m_rdy = 1'b1;
        start_run(2'b11, 8'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
            cfg_start = 1'b0;
            s_vld = pv_vld[i];
            m_rdy = pv_rdy[i];
        end
        tick();
        s_vld = 1'b0;
        run_to_done(1'b0, 8'h11, 20);
        tick(); tick();
        chk("perf_stall", {32'd0, stall_cycles}, 64'd3);
        chk("perf_starve", {32'd0, starve_cycles}, 64'd2);
        chk("perf_q_empty", 64'(exp_q.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
